// File: rtl/code_lock_fsm_if.sv
// Operator-side bundle for the code lock.
// Switches/buttons in, lamp/status outputs back.
interface code_lock_fsm_if #(
  parameter int WIDTH     = 2,
  parameter int DIGITS    = 3,
  parameter int MAX_TRIES = 3
);
  localparam int CW = $clog2(DIGITS + 1);
  localparam int TW = $clog2(MAX_TRIES + 1);

  logic [WIDTH-1:0] Switch;
  logic             Enter;
  logic             Program;
  logic             Unlocked;
  logic             Error;
  logic             Locked;
  logic [CW-1:0]    DigitCount;
  logic [TW-1:0]    TriesLeft;

  modport master (
    output Switch, Enter, Program,
    input  Unlocked, Error, Locked, DigitCount, TriesLeft
  );

  modport slave (
    input  Switch, Enter, Program,
    output Unlocked, Error, Locked, DigitCount, TriesLeft
  );
endinterface

// File: rtl/code_lock_fsm.sv
// Combination lock: digit entry, compare, lockout
// after repeated failures, and code reprogramming.
module code_lock_fsm #(
  parameter int WIDTH       = 2,
  parameter int DIGITS      = 3,
  parameter logic [DIGITS*WIDTH-1:0] DEFAULT_CODE = 6'b01_10_11,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 16,
  parameter int TIMEOUT     = 64
) (
  input logic Clock,
  input logic Reset_n,
  code_lock_fsm_if.slave bus
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam int OW = $clog2(TIMEOUT + 2);
  localparam int NB = DIGITS * WIDTH;

  typedef enum logic [2:0] {
    IDLE, ENTRY, CHECK, OPEN, PROG, LOCKOUT
  } state_t;

  state_t           state, state_n;
  logic             enter_q;
  logic [CW-1:0]    dcnt, dcnt_n;
  logic [TW-1:0]    tries, tries_n;
  logic [LW-1:0]    lock_cnt, lock_n;
  logic [OW-1:0]    tmo, tmo_n;
  logic             err, err_n;
  logic             cap, commit;
  logic             enter_rise, tmo_exp;
  logic [WIDTH-1:0] digits_q [DIGITS];
  logic [NB-1:0]    code;
  logic [NB-1:0]    entry_code, prog_code;

  assign enter_rise = bus.Enter & ~enter_q;
  assign tmo_exp = (TIMEOUT != 0) &&
                   (tmo == OW'(TIMEOUT - 1));

  // Flatten captured digits; first digit is the MSB field.
  // The commit image takes the final digit live from Switch.
  always_comb begin
    entry_code = '0;
    prog_code  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      entry_code[(DIGITS-1-i)*WIDTH +: WIDTH] = digits_q[i];
      prog_code[(DIGITS-1-i)*WIDTH +: WIDTH] =
        (i == DIGITS - 1) ? bus.Switch : digits_q[i];
    end
  end

  // Next-state and next-register decode.
  always_comb begin
    state_n = state;
    dcnt_n  = dcnt;
    tries_n = tries;
    lock_n  = lock_cnt;
    tmo_n   = tmo;
    err_n   = 1'b0;
    cap     = 1'b0;
    commit  = 1'b0;
    unique case (state)
      IDLE: begin
        if (enter_rise) begin
          cap     = 1'b1;
          dcnt_n  = CW'(1);
          tmo_n   = '0;
          state_n = (DIGITS == 1) ? CHECK : ENTRY;
        end
      end
      ENTRY, PROG: begin
        if (enter_rise) begin
          cap    = 1'b1;
          dcnt_n = dcnt + CW'(1);
          tmo_n  = '0;
          if (dcnt_n == CW'(DIGITS)) begin
            if (state == PROG) begin
              commit  = 1'b1;
              dcnt_n  = '0;
              state_n = OPEN;
            end else begin
              state_n = CHECK;
            end
          end
        end else if (tmo_exp) begin
          dcnt_n  = '0;
          tmo_n   = '0;
          state_n = (state == PROG) ? OPEN : IDLE;
        end else if (TIMEOUT != 0) begin
          tmo_n = tmo + OW'(1);
        end
      end
      CHECK: begin
        dcnt_n = '0;
        if (entry_code == code) begin
          tries_n = TW'(MAX_TRIES);
          state_n = OPEN;
        end else begin
          tries_n = tries - TW'(1);
          err_n   = 1'b1;
          if (tries == TW'(1)) begin
            lock_n  = LW'(LOCK_CYCLES - 1);
            state_n = LOCKOUT;
          end else begin
            state_n = IDLE;
          end
        end
      end
      OPEN: begin
        if (enter_rise) begin
          dcnt_n  = '0;
          tmo_n   = '0;
          state_n = bus.Program ? PROG : IDLE;
        end
      end
      LOCKOUT: begin
        if (lock_cnt == '0) begin
          tries_n = TW'(MAX_TRIES);
          state_n = IDLE;
        end else begin
          lock_n = lock_cnt - LW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and control registers.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      enter_q  <= 1'b1;
      dcnt     <= '0;
      tries    <= TW'(MAX_TRIES);
      lock_cnt <= '0;
      tmo      <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      enter_q  <= bus.Enter;
      dcnt     <= dcnt_n;
      tries    <= tries_n;
      lock_cnt <= lock_n;
      tmo      <= tmo_n;
      err      <= err_n;
    end
  end

  // Digit capture buffer and stored code.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DIGITS; i++) digits_q[i] <= '0;
      code <= DEFAULT_CODE;
    end else begin
      if (cap) begin
        for (int i = 0; i < DIGITS; i++)
          if (dcnt == CW'(i)) digits_q[i] <= bus.Switch;
      end
      if (commit) code <= prog_code;
    end
  end

  assign bus.Unlocked   = (state == OPEN) || (state == PROG);
  assign bus.Locked     = (state == LOCKOUT);
  assign bus.Error      = err;
  assign bus.DigitCount = dcnt;
  assign bus.TriesLeft  = tries;

endmodule

// File: tb/tb_code_lock_fsm.sv
// Directed scenario bench for code_lock_fsm.
// Default parameters; stored code is 1,2,3.
module tb_code_lock_fsm;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   dc_seen;
  int   unl_mid;

  code_lock_fsm_if #(
    .WIDTH(2), .DIGITS(3), .MAX_TRIES(3)
  ) bus ();

  code_lock_fsm #(
    .WIDTH(2), .DIGITS(3),
    .DEFAULT_CODE(6'b01_10_11),
    .MAX_TRIES(3), .LOCK_CYCLES(16), .TIMEOUT(64)
  ) dut (
    .Clock(clk),
    .Reset_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One press: Enter high for one clock, low for one.
  task automatic press(input logic [1:0] d);
    bus.Switch = d;
    bus.Enter  = 1'b1;
    tick();
    dc_seen = int'(bus.DigitCount);
    unl_mid = int'(bus.Unlocked);
    bus.Enter = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    bus.Enter   = 1'b0;
    bus.Program = 1'b0;
    bus.Switch  = 2'd0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (bus.Unlocked !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_unlocked got %b want 0", bus.Unlocked);
    end
    n_cmp++;
    if (bus.Locked !== 1'b0 || bus.Error !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_lock_err got %b%b want 00",
               bus.Locked, bus.Error);
    end
    n_cmp++;
    if (bus.DigitCount !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_dc got %0d want 0", bus.DigitCount);
    end
    n_cmp++;
    if (bus.TriesLeft !== 2'd3) begin
      n_bad++;
      $display("FAIL reset_tries got %0d want 3", bus.TriesLeft);
    end
  endtask

  task automatic test_open();
    logic [1:0] seq [3];
    seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3;
    for (int i = 0; i < 3; i++) begin
      press(seq[i]);
      n_cmp++;
      if (dc_seen !== i + 1) begin
        n_bad++;
        $display("FAIL open_dc%0d got %0d want %0d",
                 i, dc_seen, i + 1);
      end
    end
    n_cmp++;
    if (unl_mid !== 0) begin
      n_bad++;
      $display("FAIL open_early got %0d want 0", unl_mid);
    end
    n_cmp++;
    if (bus.Unlocked !== 1'b1 || bus.Error !== 1'b0) begin
      n_bad++;
      $display("FAIL open_unl got %b/%b want 1/0",
               bus.Unlocked, bus.Error);
    end
    n_cmp++;
    if (bus.TriesLeft !== 2'd3 || bus.DigitCount !== 2'd0) begin
      n_bad++;
      $display("FAIL open_tries got %0d/%0d want 3/0",
               bus.TriesLeft, bus.DigitCount);
    end
    press(2'd0);
    n_cmp++;
    if (bus.Unlocked !== 1'b0) begin
      n_bad++;
      $display("FAIL relock got %b want 0", bus.Unlocked);
    end
  endtask

  task automatic test_fail_lockout();
    int cnt;
    for (int k = 1; k <= 3; k++) begin
      press(2'd1);
      press(2'd2);
      press(2'd0);
      n_cmp++;
      if (bus.Error !== 1'b1 || bus.TriesLeft !== 2'(3 - k)) begin
        n_bad++;
        $display("FAIL fail%0d_err got %b/%0d want 1/%0d",
                 k, bus.Error, bus.TriesLeft, 3 - k);
      end
      n_cmp++;
      if (bus.Locked !== (k == 3)) begin
        n_bad++;
        $display("FAIL fail%0d_locked got %b want %0d",
                 k, bus.Locked, k == 3);
      end
      if (k < 3) begin
        tick();
        n_cmp++;
        if (bus.Error !== 1'b0 || bus.DigitCount !== 2'd0) begin
          n_bad++;
          $display("FAIL fail%0d_pulse got %b/%0d want 0/0",
                   k, bus.Error, bus.DigitCount);
        end
      end
    end
    cnt = 1;
    while (cnt < 100) begin
      bus.Switch = 2'd1;
      bus.Enter = (cnt % 2 == 1);
      tick();
      if (cnt == 1) begin
        n_cmp++;
        if (bus.Error !== 1'b0) begin
          n_bad++;
          $display("FAIL lock_err_width got %b want 0", bus.Error);
        end
      end
      if (!bus.Locked) break;
      cnt++;
    end
    bus.Enter = 1'b0;
    n_cmp++;
    if (cnt !== 16) begin
      n_bad++;
      $display("FAIL lock_len got %0d want 16", cnt);
    end
    n_cmp++;
    if (bus.TriesLeft !== 2'd3 || bus.DigitCount !== 2'd0) begin
      n_bad++;
      $display("FAIL lock_exit got %0d/%0d want 3/0",
               bus.TriesLeft, bus.DigitCount);
    end
    press(2'd1);
    n_cmp++;
    if (dc_seen !== 1) begin
      n_bad++;
      $display("FAIL post_lock_dc got %0d want 1", dc_seen);
    end
    press(2'd2);
    press(2'd3);
    n_cmp++;
    if (bus.Unlocked !== 1'b1) begin
      n_bad++;
      $display("FAIL post_lock_open got %b want 1", bus.Unlocked);
    end
    press(2'd0);
  endtask

  task automatic test_program();
    press(2'd1); press(2'd2); press(2'd3);
    bus.Program = 1'b1;
    press(2'd1);
    bus.Program = 1'b0;
    n_cmp++;
    if (bus.Unlocked !== 1'b1 || bus.DigitCount !== 2'd0) begin
      n_bad++;
      $display("FAIL prog_enter got %b/%0d want 1/0",
               bus.Unlocked, bus.DigitCount);
    end
    press(2'd3);
    n_cmp++;
    if (dc_seen !== 1) begin
      n_bad++;
      $display("FAIL prog_dc got %0d want 1", dc_seen);
    end
    press(2'd0);
    press(2'd2);
    n_cmp++;
    if (bus.Unlocked !== 1'b1) begin
      n_bad++;
      $display("FAIL prog_done got %b want 1", bus.Unlocked);
    end
    press(2'd0);
    press(2'd1); press(2'd2); press(2'd3);
    n_cmp++;
    if (bus.Error !== 1'b1 || bus.Unlocked !== 1'b0) begin
      n_bad++;
      $display("FAIL old_code got err %b unl %b want 1/0",
               bus.Error, bus.Unlocked);
    end
    tick();
    press(2'd3); press(2'd0); press(2'd2);
    n_cmp++;
    if (bus.Unlocked !== 1'b1 || bus.TriesLeft !== 2'd3) begin
      n_bad++;
      $display("FAIL new_code got unl %b tries %0d want 1/3",
               bus.Unlocked, bus.TriesLeft);
    end
    press(2'd0);
  endtask

  task automatic test_timeout();
    press(2'd1);
    press(2'd2);
    repeat (62) tick();
    n_cmp++;
    if (bus.DigitCount !== 2'd2) begin
      n_bad++;
      $display("FAIL tmo_early got %0d want 2", bus.DigitCount);
    end
    tick();
    n_cmp++;
    if (bus.DigitCount !== 2'd0 || bus.Error !== 1'b0) begin
      n_bad++;
      $display("FAIL tmo_abort got %0d/%b want 0/0",
               bus.DigitCount, bus.Error);
    end
    tick();
    n_cmp++;
    if (bus.Error !== 1'b0 || bus.TriesLeft !== 2'd3) begin
      n_bad++;
      $display("FAIL tmo_noerr got %b/%0d want 0/3",
               bus.Error, bus.TriesLeft);
    end
    press(2'd1); press(2'd2); press(2'd3);
    n_cmp++;
    if (bus.Unlocked !== 1'b1) begin
      n_bad++;
      $display("FAIL tmo_reopen got %b want 1", bus.Unlocked);
    end
    press(2'd0);
  endtask

  task automatic test_expiry_edge();
    press(2'd1);
    repeat (62) tick();
    press(2'd2);
    n_cmp++;
    if (dc_seen !== 2) begin
      n_bad++;
      $display("FAIL exp_edge_dc got %0d want 2", dc_seen);
    end
    press(2'd3);
    n_cmp++;
    if (bus.Unlocked !== 1'b1) begin
      n_bad++;
      $display("FAIL exp_edge_open got %b want 1", bus.Unlocked);
    end
    press(2'd0);
  endtask

  task automatic test_reset_cases();
    bus.Switch = 2'd1;
    bus.Enter  = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (bus.DigitCount !== 2'd0) begin
      n_bad++;
      $display("FAIL held_enter got %0d want 0", bus.DigitCount);
    end
    bus.Enter = 1'b0;
    tick();
    press(2'd1); press(2'd2); press(2'd3);
    bus.Program = 1'b1;
    press(2'd0);
    bus.Program = 1'b0;
    press(2'd3);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.Unlocked, bus.Error, bus.Locked} !== 3'b000 ||
        bus.DigitCount !== 2'd0 || bus.TriesLeft !== 2'd3) begin
      n_bad++;
      $display("FAIL mid_prog_rst got %b%b%b dc %0d tl %0d",
               bus.Unlocked, bus.Error, bus.Locked,
               bus.DigitCount, bus.TriesLeft);
    end
    tick();
    rst_n = 1'b1;
    tick();
    press(2'd1); press(2'd2); press(2'd3);
    n_cmp++;
    if (bus.Unlocked !== 1'b1) begin
      n_bad++;
      $display("FAIL code_revert got %b want 1", bus.Unlocked);
    end
  endtask

  initial begin
    test_reset();
    test_open();
    test_fail_lockout();
    test_program();
    do_reset();
    test_timeout();
    test_expiry_edge();
    test_reset_cases();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/code_lock_fsm.md
# code_lock_fsm

Parametrised combination-lock controller: the operator enters a code as a sequence of `DIGITS` switch values, one per rising edge of `Enter`. The block compares the sequence against a stored code, opens on a match and counts failures, applying a timed lockout after `MAX_TRIES` consecutive failures. While open, the operator can reprogram the code. It sits between the debounced board switches/buttons and the LED/status outputs, and supersedes the fixed 2-bit, hard-coded-sequence menu FSM.

## Interface
- `WIDTH`, 2: bits per digit (`Switch` width).
- `DIGITS`, 3: digits per code, ≥1.
- `DEFAULT_CODE`, 6'b01_10_11: code loaded at reset, `DIGITS*WIDTH` bits; first digit is the MSB field.
- `MAX_TRIES`, 3: consecutive failed checks before lockout, ≥1.
- `LOCK_CYCLES`, 16: lockout duration in clocks, ≥1.
- `TIMEOUT`, 64: idle clocks allowed between digits during entry; 0 disables the timeout.
- `Clock`  in  1  sole clock, rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `Switch`  in  WIDTH  digit value; already synchronous to `Clock`.
- `Enter`  in  1  debounced, synchronous button; only its rising edge is used.
- `Program`  in  1  level, sampled with an `Enter` edge in OPEN.
- `Unlocked`  out  1  high in OPEN and PROG.
- `Error`  out  1  one-cycle pulse on a failed check.
- `Locked`  out  1  high in LOCKOUT.
- `DigitCount`  out  $clog2(DIGITS+1)  digits captured in the current sequence.
- `TriesLeft`  out  $clog2(MAX_TRIES+1)  remaining attempts.

## Operation
- Edge detect: `Enter_q` is registered. An edge is `Enter & ~Enter_q`. `Enter_q` resets to 1, so `Enter` held high through reset release gives no edge. `Switch` is sampled in the edge cycle.
- States: IDLE, ENTRY, CHECK, OPEN, PROG, LOCKOUT.
- IDLE:
  - An edge captures digit 0 and sets `DigitCount`=1.
  - Goes to ENTRY, or to CHECK if `DIGITS`=1.
- ENTRY:
  - Each edge stores `Switch` at index `DigitCount` and increments `DigitCount`.
  - The edge that makes `DigitCount`=`DIGITS` moves to CHECK.
- CHECK (exactly one cycle; edges ignored):
  - Match:
    - Next state is OPEN.
    - `TriesLeft` reloads to `MAX_TRIES`.
  - Mismatch:
    - `TriesLeft` decrements.
    - If the new value is 0, next state is LOCKOUT with the lock counter set to `LOCK_CYCLES`-1.
    - Otherwise next state is IDLE and `Error` pulses.
    - On the final failure, `Error` also pulses and the state goes to LOCKOUT.
  - `DigitCount` clears on leaving CHECK.
- OPEN:
  - An edge with `Program`=0 relocks: next state is IDLE.
  - An edge with `Program`=1 goes to PROG; that edge captures no digit.
- PROG:
  - Edges capture digits into a shadow buffer, exactly as in ENTRY.
  - The `DIGITS`-th edge commits the shadow buffer to the code register and returns to OPEN.
- Timeout:
  - A counter runs in ENTRY and PROG and clears on every accepted edge.
  - After `TIMEOUT` consecutive cycles with no edge, the sequence aborts:
    - ENTRY goes to IDLE; PROG goes to OPEN with the code unchanged.
    - `DigitCount` clears.
    - The abort does not count as a failure and does not pulse `Error`.
  - If an edge occurs in the expiry cycle, the edge wins.
- LOCKOUT:
  - Edges are ignored.
  - The counter decrements each cycle; at 0 the next state is IDLE and `TriesLeft` reloads to `MAX_TRIES`.
  - An `Enter` held high across the exit needs a fresh rising edge.
- Reset (asynchronous, any state, mid-sequence included):
  - State IDLE; code register = `DEFAULT_CODE`; `TriesLeft`=`MAX_TRIES`.
  - `DigitCount`, `Unlocked`, `Error`, `Locked` and all counters = 0.

## Timing
- All outputs are registered or decoded from registered state; there are no combinational paths from input to output.
- `DigitCount` reflects an edge at clock t from t+1.
- The last-digit edge at t puts the state in CHECK at t+1. `Unlocked` or `Error` rises at t+2, as does `Locked` on the final failure.
- `Error` is high for exactly 1 cycle.
- `Locked` is high for exactly `LOCK_CYCLES` cycles. An edge is accepted at the earliest in the first cycle after `Locked` falls.
- Code commit: a new code is visible to the next CHECK, the clock after the `DIGITS`-th PROG edge.
- Minimum edge spacing is 2 clocks (`Enter` low for at least 1 cycle between presses).

## Test plan
All scenarios use default parameters (code 1,2,3).
- Reset, then enter 1,2,3 -> `DigitCount` 1,2,3. `Unlocked`=1 two clocks after the third edge. `TriesLeft`=3.
- Enter 1,2,0 three times -> `Error` pulses 1 cycle each time and `TriesLeft` goes 2,1,0. After the third attempt `Locked`=1 for exactly 16 cycles, then IDLE with `TriesLeft`=3. Edges during lockout are ignored.
- Open the lock, press `Enter` with `Program`=1, enter 3,0,2, relock, then enter 1,2,3 and 3,0,2 -> the first attempt fails with an `Error` pulse; the second gives `Unlocked`=1.
- Enter 1,2, then wait 64 idle cycles -> `DigitCount` returns to 0, no `Error`, `TriesLeft` unchanged. A following 1,2,3 opens the lock.
- `Enter` held high across reset release -> no digit captured. Assert `Reset_n`=0 mid-PROG -> code reverts to 1,2,3 and all outputs are 0.
- Edge coincident with the timeout expiry cycle -> digit accepted, sequence continues.
